// File: rtl/bp_stall_profiler_ctrl.sv
// bp_stall_profiler_ctrl: per-reason saturating stall counters with an atomic
// snapshot into a shadow bank that is streamed out over a valid/ready port.
// Live counting never stops, including while the shadow bank is being drained.
module bp_stall_profiler_ctrl #(
  parameter int num_reasons_p  = 31,
  parameter int reason_width_p = 6,
  parameter int ctr_width_p    = 32
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      en_i,
  input  logic                      stall_v_i,
  input  logic [reason_width_p-1:0] stall_reason_i,
  input  logic                      cmd_v_i,
  input  logic [1:0]                cmd_i,
  output logic                      cmd_ready_o,
  output logic                      data_v_o,
  output logic [ctr_width_p-1:0]    data_o,
  output logic [reason_width_p-1:0] data_idx_o,
  output logic                      data_last_o,
  input  logic                      data_ready_i,
  output logic                      busy_o,
  output logic                      overflow_o
);

  localparam logic [0:0] e_idle  = 1'b0;
  localparam logic [0:0] e_drain = 1'b1;

  localparam logic [reason_width_p-1:0] last_idx = reason_width_p'(num_reasons_p - 1);
  localparam logic [ctr_width_p-1:0]    ctr_max  = '1;

  logic [0:0]                state;
  logic [reason_width_p-1:0] idx;
  logic [ctr_width_p-1:0]    live   [num_reasons_p];
  logic [ctr_width_p-1:0]    shadow [num_reasons_p];
  logic                      overflow;

  logic                      cmd_fire;
  logic                      do_clear;
  logic                      do_snap;
  logic                      sample;
  logic                      sat_hit;
  logic [reason_width_p-1:0] bin;
  logic [ctr_width_p-1:0]    beat;

  function automatic logic [ctr_width_p-1:0] sat_inc(input logic [ctr_width_p-1:0] v);
    return (v == ctr_max) ? v : v + ctr_width_p'(1);
  endfunction

  // Commands are only taken in idle; bit 1 of the code clears, bit 0 snapshots.
  assign cmd_fire = cmd_v_i & (state == e_idle);
  assign do_clear = cmd_fire & cmd_i[1];
  assign do_snap  = cmd_fire & cmd_i[0];
  assign sample   = en_i & stall_v_i;
  assign bin      = (stall_reason_i > last_idx) ? last_idx : stall_reason_i;

  // Flag an increment that lands on a saturated counter; a same-cycle clear wins.
  always_comb begin
    sat_hit = 1'b0;
    for (int i = 0; i < num_reasons_p; i++) begin
      if (sample && !do_clear && (bin == reason_width_p'(i)) && (live[i] == ctr_max)) begin
        sat_hit = 1'b1;
      end
    end
  end

  // Live bank: apply a clear first, then fold in this cycle's sample.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < num_reasons_p; i++) begin
      if (reset_i) begin
        live[i] <= '0;
      end else if (sample && (bin == reason_width_p'(i))) begin
        live[i] <= sat_inc(do_clear ? '0 : live[i]);
      end else if (do_clear) begin
        live[i] <= '0;
      end
    end
  end

  // Shadow bank captures the registered live values, excluding this cycle's sample.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < num_reasons_p; i++) begin
      if (reset_i) begin
        shadow[i] <= '0;
      end else if (do_snap) begin
        shadow[i] <= live[i];
      end
    end
  end

  // Sticky saturation flag, cleared together with the live bank.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      overflow <= 1'b0;
    end else if (do_clear) begin
      overflow <= 1'b0;
    end else if (sat_hit) begin
      overflow <= 1'b1;
    end
  end

  // Command/drain FSM: one beat per handshake, back to idle after the last index.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= e_idle;
      idx   <= '0;
    end else begin
      case (state)
        e_idle: begin
          if (do_snap) begin
            state <= e_drain;
            idx   <= '0;
          end
        end
        e_drain: begin
          if (data_ready_i) begin
            if (idx == last_idx) begin
              state <= e_idle;
              idx   <= '0;
            end else begin
              idx <= idx + reason_width_p'(1);
            end
          end
        end
        default: begin
          state <= e_idle;
          idx   <= '0;
        end
      endcase
    end
  end

  // Select the shadow entry addressed by the drain index.
  always_comb begin
    beat = '0;
    for (int i = 0; i < num_reasons_p; i++) begin
      if (idx == reason_width_p'(i)) begin
        beat = shadow[i];
      end
    end
  end

  assign cmd_ready_o = (state == e_idle);
  assign busy_o      = (state == e_drain);
  assign data_v_o    = (state == e_drain);
  assign data_o      = data_v_o ? beat : '0;
  assign data_idx_o  = data_v_o ? idx : '0;
  assign data_last_o = data_v_o && (idx == last_idx);
  assign overflow_o  = overflow;

endmodule

// File: tb/tb_bp_stall_profiler_ctrl.sv
// Bench for bp_stall_profiler_ctrl: a 32-bit and a 4-bit counter instance share
// the same stimulus and are compared every cycle against an unbounded-count model.
module tb_bp_stall_profiler_ctrl;

  localparam int NR = 31;
  localparam int RW = 6;
  localparam int CW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic reset, en, stall_v, cmd_v, data_ready;
  logic [RW-1:0] reason;
  logic [1:0]    cmd;

  logic          cmd_ready, data_v, data_last, busy, overflow;
  logic [CW-1:0] data;
  logic [RW-1:0] data_idx;

  logic          cmd_ready_s, data_v_s, data_last_s, busy_s, overflow_s;
  logic [SW-1:0] data_s;
  logic [RW-1:0] data_idx_s;

  always #5 clk = ~clk;

  bp_stall_profiler_ctrl #(.num_reasons_p(NR), .reason_width_p(RW), .ctr_width_p(CW)) dut (
    .clk_i(clk), .reset_i(reset), .en_i(en), .stall_v_i(stall_v), .stall_reason_i(reason),
    .cmd_v_i(cmd_v), .cmd_i(cmd), .cmd_ready_o(cmd_ready), .data_v_o(data_v), .data_o(data),
    .data_idx_o(data_idx), .data_last_o(data_last), .data_ready_i(data_ready),
    .busy_o(busy), .overflow_o(overflow)
  );

  bp_stall_profiler_ctrl #(.num_reasons_p(NR), .reason_width_p(RW), .ctr_width_p(SW)) dut_sat (
    .clk_i(clk), .reset_i(reset), .en_i(en), .stall_v_i(stall_v), .stall_reason_i(reason),
    .cmd_v_i(cmd_v), .cmd_i(cmd), .cmd_ready_o(cmd_ready_s), .data_v_o(data_v_s), .data_o(data_s),
    .data_idx_o(data_idx_s), .data_last_o(data_last_s), .data_ready_i(data_ready),
    .busy_o(busy_s), .overflow_o(overflow_s)
  );

  // Model: raw (unbounded) counts, snapshot copy, and drain position.
  longint live [NR];
  longint shadow [NR];
  bit     m_busy;
  int     m_idx;
  bit     m_acc;

  longint got [NR];
  longint got_s [NR];
  int     nbeats, nlast, last_at, drain_cycles;
  int     total = 0;
  int     bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, act, exp);
    end
  endtask

  function automatic longint clip(input longint v, input int w);
    longint m = (longint'(1) << w) - 1;
    return (v > m) ? m : v;
  endfunction

  function automatic bit m_ovf(input int w);
    longint m = (longint'(1) << w) - 1;
    for (int i = 0; i < NR; i++) if (live[i] > m) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_outs();
    check_eq("cmd_ready", cmd_ready, !m_busy);
    check_eq("busy", busy, m_busy);
    check_eq("data_v", data_v, m_busy);
    check_eq("data_last", data_last, m_busy && (m_idx == NR-1));
    check_eq("overflow", overflow, m_ovf(CW));
    check_eq("cmd_ready_s", cmd_ready_s, !m_busy);
    check_eq("data_v_s", data_v_s, m_busy);
    check_eq("data_last_s", data_last_s, m_busy && (m_idx == NR-1));
    check_eq("overflow_s", overflow_s, m_ovf(SW));
    if (m_busy) begin
      check_eq("data_idx", data_idx, m_idx);
      check_eq("data", data, clip(shadow[m_idx], CW));
      check_eq("data_idx_s", data_idx_s, m_idx);
      check_eq("data_s", data_s, clip(shadow[m_idx], SW));
    end
  endtask

  // One clock: capture a handshake beat, advance the model, then compare.
  task automatic step();
    int  b;
    bit  acc;
    if (data_v && data_ready && (int'(data_idx) < NR)) begin
      got[data_idx]   = data;
      got_s[data_idx] = data_s;
      nbeats++;
      if (data_last) begin
        nlast++;
        last_at = data_idx;
      end
    end
    m_acc = 1'b0;
    if (reset) begin
      for (int i = 0; i < NR; i++) begin
        live[i]   = 0;
        shadow[i] = 0;
      end
      m_busy = 1'b0;
      m_idx  = 0;
    end else begin
      acc   = cmd_v && !m_busy;
      m_acc = acc;
      b     = (int'(reason) >= NR) ? NR-1 : int'(reason);
      if (m_busy && data_ready) begin
        if (m_idx == NR-1) begin
          m_busy = 1'b0;
          m_idx  = 0;
        end else begin
          m_idx++;
        end
      end else if (acc && cmd[0]) begin
        shadow = live;
        m_busy = 1'b1;
        m_idx  = 0;
      end
      if (acc && cmd[1]) for (int i = 0; i < NR; i++) live[i] = 0;
      if (en && stall_v) live[b]++;
    end
    @(posedge clk);
    #1;
    check_outs();
  endtask

  task automatic idle_inputs();
    reset = 1'b0; en = 1'b1; stall_v = 1'b0; reason = '0;
    cmd_v = 1'b0; cmd = 2'd0; data_ready = 1'b0;
  endtask

  task automatic samples(input int r, input int n, input bit e);
    for (int i = 0; i < n; i++) begin
      en = e; stall_v = 1'b1; reason = RW'(r);
      step();
    end
    en = 1'b1; stall_v = 1'b0;
  endtask

  task automatic command(input int c);
    cmd_v = 1'b1; cmd = 2'(c);
    step();
    cmd_v = 1'b0;
  endtask

  task automatic run_drain(input bit rnd, input int ns, input int nr);
    int k = 0;
    logic [63:0] pd;
    logic [RW-1:0] pi;
    bit held;
    for (int i = 0; i < NR; i++) begin got[i] = 0; got_s[i] = 0; end
    nbeats = 0; nlast = 0; last_at = -1;
    while ((m_busy || busy) && k < 1000) begin
      data_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stall_v = (k < ns); reason = RW'(nr); en = 1'b1;
      held = data_v && !data_ready; pd = data; pi = data_idx;
      step();
      k++;
      if (held) begin
        check_eq("hold_data", data, pd);
        check_eq("hold_idx", data_idx, pi);
      end
    end
    drain_cycles = k;
    data_ready = 1'b0; stall_v = 1'b0;
    check_eq("drain_done", busy, 0);
  endtask

  function automatic longint sum_got();
    longint s = 0;
    for (int i = 0; i < NR; i++) s += got[i] + got_s[i];
    return s;
  endfunction

  initial begin
    int k;
    longint others;
    for (int i = 0; i < NR; i++) begin live[i] = 0; shadow[i] = 0; end
    m_busy = 1'b0; m_idx = 0;
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_data_v", data_v, 0);
    check_eq("rst_data_last", data_last, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_data", data, 0);
    check_eq("rst_data_idx", data_idx, 0);
    check_eq("rst_overflow", overflow, 0);

    // Basic count and drain
    samples(12, 5, 1'b1);
    samples(0, 3, 1'b1);
    command(1);
    run_drain(1'b0, 0, 0);
    check_eq("basic_beats", nbeats, NR);
    check_eq("basic_cycles", drain_cycles, NR);
    check_eq("basic_idx0", got[0], 3);
    check_eq("basic_idx12", got[12], 5);
    others = 0;
    for (int i = 1; i < NR; i++) if (i != 12) others += got[i];
    check_eq("basic_others", others, 0);
    check_eq("basic_nlast", nlast, 1);
    check_eq("basic_last_at", last_at, NR-1);

    // Out-of-range reason and enable gating
    command(2);
    samples(45, 2, 1'b1);
    samples(7, 4, 1'b0);
    command(1);
    run_drain(1'b0, 0, 0);
    check_eq("oor_idx30", got[30], 2);
    check_eq("gated_idx7", got[7], 0);

    // Snapshot isolation under backpressure
    command(2);
    samples(3, 10, 1'b1);
    stall_v = 1'b1; reason = RW'(3);
    command(3);
    stall_v = 1'b0;
    run_drain(1'b1, 20, 3);
    check_eq("snap_idx3", got[3], 10);
    command(1);
    run_drain(1'b0, 0, 0);
    check_eq("snap2_idx3", got[3], 21);

    // Saturation on the 4-bit instance
    command(2);
    samples(5, 17, 1'b1);
    check_eq("sat_ovf_narrow", overflow_s, 1);
    check_eq("sat_ovf_wide", overflow, 0);
    command(1);
    run_drain(1'b0, 0, 0);
    check_eq("sat_narrow_idx5", got_s[5], 15);
    check_eq("sat_wide_idx5", got[5], 17);
    stall_v = 1'b1; reason = RW'(5);
    command(2);
    stall_v = 1'b0;
    check_eq("satclr_ovf_narrow", overflow_s, 0);
    command(1);
    run_drain(1'b0, 0, 0);
    check_eq("satclr_narrow_idx5", got_s[5], 1);
    en = 1'b0; stall_v = 1'b1; reason = RW'(5);
    command(2);
    en = 1'b1; stall_v = 1'b0;
    command(1);
    run_drain(1'b0, 0, 0);
    check_eq("clr_gated_idx5", got[5], 0);
    check_eq("clr_gated_ovf", overflow_s, 0);

    // Command hold-off: a clear withdrawn while busy has no effect
    samples(9, 6, 1'b1);
    command(1);
    cmd_v = 1'b1; cmd = 2'd2;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("holdoff_ready", cmd_ready, 0);
    end
    cmd_v = 1'b0;
    run_drain(1'b0, 0, 0);
    command(1);
    run_drain(1'b0, 0, 0);
    check_eq("holdoff_unchanged", got[9], 6);

    // Command hold-off: a clear held through the drain lands right after it
    command(1);
    cmd_v = 1'b1; cmd = 2'd2; data_ready = 1'b1;
    k = 0;
    do begin
      step();
      k++;
    end while (!m_acc && k < 200);
    cmd_v = 1'b0; data_ready = 1'b0;
    check_eq("holdoff_accept_cycle", k, NR + 1);
    command(1);
    run_drain(1'b0, 0, 0);
    check_eq("holdoff_cleared", got[9], 0);

    // Reset at beat 8 of a drain
    samples(4, 3, 1'b1);
    command(1);
    data_ready = 1'b1;
    k = 0;
    while (m_idx != 8 && k < 100) begin
      step();
      k++;
    end
    check_eq("midrst_at_beat8", data_idx, 8);
    reset = 1'b1;
    step();
    reset = 1'b0; data_ready = 1'b0;
    check_eq("midrst_data_v", data_v, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_cmd_ready", cmd_ready, 1);
    command(1);
    run_drain(1'b0, 0, 0);
    check_eq("midrst_counts", sum_got(), 0);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      reset      = ($urandom_range(0, 399) == 0);
      en         = ($urandom_range(0, 3) != 0);
      stall_v    = 1'($urandom_range(0, 1));
      reason     = RW'($urandom_range(0, 63));
      cmd_v      = ($urandom_range(0, 11) == 0);
      cmd        = 2'($urandom_range(0, 3));
      data_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    idle_inputs();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
